n64a_vdemux: RTL and testbench

Front-end demultiplexer for the N64 digital video bus. It samples the 7-bit multiplexed bus on VCLK, framed by nDSYNC, and rebuilds one parallel pixel word `{sync[3:0], R, G, B}` per 4-word group. It also derives the video mode (PAL/NTSC) and the scan type (240p/480i) from lines per field. It sits directly upstream of the test-pattern and post-processing stages, which consume `Sync_o`, `vdata_o`, `vmode` and `n64_480i`.

---
 rtl/n64a_vdemux_pkg.sv | 36 +++
 rtl/n64a_linecnt.sv | 77 +++++++
 rtl/n64a_vdemux.sv | 110 +++++++++++
 tb/tb_n64a_vdemux.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/n64a_vdemux_pkg.sv
// Shared constants and helpers for the N64 digital video demultiplexer.
// Holds the bus geometry, sync bit positions and mode threshold used by the front end.
package n64a_vdemux_pkg;

   localparam int color_width_i = 7;
   localparam int VDATA_W       = 4 + 3 * color_width_i;

   localparam int VDATA_I_FU_SLICE_HI = 24;
   localparam int VDATA_I_FU_SLICE_LO = 0;

   localparam logic [9:0] VMODE_PAL_THRES = 10'd287;
   localparam logic [9:0] LINE_CNT_MAX    = 10'd1023;

   localparam int VSYNC = 3;
   localparam int CLAMP = 2;
   localparam int HSYNC = 1;
   localparam int CSYNC = 0;

   localparam logic [3:0] SYNC_IDLE = 4'hF;

   typedef struct packed {
      logic [3:0]               sync;
      logic [color_width_i-1:0] r;
      logic [color_width_i-1:0] g;
      logic [color_width_i-1:0] b;
   } pixel_t;

   function automatic logic rose(input logic prev, input logic cur);
      return ~prev & cur;
   endfunction

   function automatic logic fell(input logic prev, input logic cur);
      return prev & ~cur;
   endfunction

endpackage

// File: rtl/n64a_linecnt.sv
// Per-field line counter that classifies the incoming video as PAL/NTSC and 240p/480i.
// Evaluated only on sync samples; a falling nVSYNC closes the field.
module n64a_linecnt
   import n64a_vdemux_pkg::*;
(
   input  logic       VCLK,
   input  logic       nRST,
   input  logic       sync_strb_i,
   input  logic [3:0] sync_cur_i,
   input  logic [3:0] sync_prev_i,
   output logic       vmode_o,
   output logic       n64_480i_o,
   output logic       mode_valid_o
);

   logic [9:0] line_cnt_q, line_cnt_d;
   logic [9:0] prev_cnt_q, prev_cnt_d;
   logic [1:0] field_cnt_q, field_cnt_d;
   logic       vmode_q, vmode_d;
   logic       n64_480i_q, n64_480i_d;
   logic       mode_valid_q, mode_valid_d;

   logic hs_rise;
   logic vs_fall;

   assign hs_rise = rose(sync_prev_i[HSYNC], sync_cur_i[HSYNC]);
   assign vs_fall = fell(sync_prev_i[VSYNC], sync_cur_i[VSYNC]);

   always_comb begin
      line_cnt_d   = line_cnt_q;
      prev_cnt_d   = prev_cnt_q;
      field_cnt_d  = field_cnt_q;
      vmode_d      = vmode_q;
      n64_480i_d   = n64_480i_q;
      mode_valid_d = mode_valid_q;

      if (sync_strb_i) begin
         if (hs_rise && (line_cnt_q != LINE_CNT_MAX))
            line_cnt_d = line_cnt_q + 10'd1;

         // Field end judges the count accumulated before this sample; the clear overrides any increment.
         if (vs_fall) begin
            vmode_d    = (line_cnt_q > VMODE_PAL_THRES);
            n64_480i_d = (line_cnt_q[0] != prev_cnt_q[0]);
            prev_cnt_d = line_cnt_q;
            if (field_cnt_q != 2'd2)
               field_cnt_d = field_cnt_q + 2'd1;
            line_cnt_d = 10'd0;
         end
      end

      mode_valid_d = (field_cnt_d == 2'd2);
   end

   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         line_cnt_q   <= 10'd0;
         prev_cnt_q   <= 10'd0;
         field_cnt_q  <= 2'd0;
         vmode_q      <= 1'b0;
         n64_480i_q   <= 1'b0;
         mode_valid_q <= 1'b0;
      end else begin
         line_cnt_q   <= line_cnt_d;
         prev_cnt_q   <= prev_cnt_d;
         field_cnt_q  <= field_cnt_d;
         vmode_q      <= vmode_d;
         n64_480i_q   <= n64_480i_d;
         mode_valid_q <= mode_valid_d;
      end
   end

   assign vmode_o      = vmode_q;
   assign n64_480i_o   = n64_480i_q;
   assign mode_valid_o = mode_valid_q;

endmodule

// File: rtl/n64a_vdemux.sv
// N64 video bus front end: rebuilds {sync, R, G, B} pixels from the 4-word multiplexed bus
// and reports the detected video mode and scan type.
module n64a_vdemux
   import n64a_vdemux_pkg::*;
(
   input  logic                     VCLK,
   input  logic                     nRST,
   input  logic                     nDSYNC,
   input  logic [color_width_i-1:0] D_i,
   output logic [3:0]               Sync_o,
   output logic [VDATA_W-1:0]       vdata_o,
   output logic                     pix_strb,
   output logic                     vmode,
   output logic                     n64_480i,
   output logic                     mode_valid
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_RED  = 2'd1,
      ST_GRN  = 2'd2,
      ST_BLU  = 2'd3
   } phase_e;

   phase_e                   state_q, state_d;
   logic [3:0]               sync_q, sync_d;
   logic [color_width_i-1:0] r_q, r_d;
   logic [color_width_i-1:0] g_q, g_d;
   pixel_t                   vdata_q, vdata_d;
   logic                     pix_strb_q, pix_strb_d;

   logic sync_strb;

   assign sync_strb = ~nDSYNC;

   always_comb begin
      state_d    = state_q;
      sync_d     = sync_q;
      r_d        = r_q;
      g_d        = g_q;
      vdata_d    = vdata_q;
      pix_strb_d = 1'b0;

      // A sync word always restarts the group, dropping any partially captured pixel.
      if (sync_strb) begin
         sync_d  = D_i[3:0];
         state_d = ST_RED;
      end else begin
         case (state_q)
            ST_RED: begin
               r_d     = D_i;
               state_d = ST_GRN;
            end
            ST_GRN: begin
               g_d     = D_i;
               state_d = ST_BLU;
            end
            ST_BLU: begin
               vdata_d.sync = sync_q;
               vdata_d.r    = r_q;
               vdata_d.g    = g_q;
               vdata_d.b    = D_i;
               pix_strb_d   = 1'b1;
               state_d      = ST_WAIT;
            end
            default: begin
               state_d = ST_WAIT;
            end
         endcase
      end
   end

   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         state_q      <= ST_WAIT;
         sync_q       <= SYNC_IDLE;
         r_q          <= '0;
         g_q          <= '0;
         vdata_q.sync <= SYNC_IDLE;
         vdata_q.r    <= '0;
         vdata_q.g    <= '0;
         vdata_q.b    <= '0;
         pix_strb_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         r_q        <= r_d;
         g_q        <= g_d;
         vdata_q    <= vdata_d;
         pix_strb_q <= pix_strb_d;
      end
   end

   // sync_q still holds the previous sync sample here, which is what edge detection needs.
   n64a_linecnt u_linecnt (
      .VCLK         (VCLK),
      .nRST         (nRST),
      .sync_strb_i  (sync_strb),
      .sync_cur_i   (D_i[3:0]),
      .sync_prev_i  (sync_q),
      .vmode_o      (vmode),
      .n64_480i_o   (n64_480i),
      .mode_valid_o (mode_valid)
   );

   assign Sync_o   = sync_q;
   assign vdata_o  = vdata_q[VDATA_I_FU_SLICE_HI:VDATA_I_FU_SLICE_LO];
   assign pix_strb = pix_strb_q;

endmodule

// File: tb/tb_n64a_vdemux.sv
// Directed bench for n64a_vdemux: table-driven pixel path vectors plus field/mode sequences.
module tb_n64a_vdemux;

   logic        VCLK = 1'b0;
   logic        nRST = 1'b0;
   logic        nDSYNC = 1'b1;
   logic [6:0]  D_i = 7'd0;
   logic [3:0]  Sync_o;
   logic [24:0] vdata_o;
   logic        pix_strb;
   logic        vmode;
   logic        n64_480i;
   logic        mode_valid;

   int n_pass = 0;
   int n_total = 0;

   n64a_vdemux dut (
      .VCLK       (VCLK),
      .nRST       (nRST),
      .nDSYNC     (nDSYNC),
      .D_i        (D_i),
      .Sync_o     (Sync_o),
      .vdata_o    (vdata_o),
      .pix_strb   (pix_strb),
      .vmode      (vmode),
      .n64_480i   (n64_480i),
      .mode_valid (mode_valid)
   );

   always #5 VCLK = ~VCLK;

   typedef struct {
      logic        nd;
      logic [6:0]  d;
      logic        e_strb;
      logic [3:0]  e_sync;
      logic [24:0] e_vdata;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step(input logic nd, input logic [6:0] d);
      nDSYNC = nd;
      D_i    = d;
      @(posedge VCLK);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_sync"}, {28'd0, Sync_o}, 32'hF);
      check({tag, "_vdata"}, {7'd0, vdata_o}, {7'd0, 4'hF, 21'd0});
      check({tag, "_strb"}, {31'd0, pix_strb}, 32'd0);
      check({tag, "_modes"}, {29'd0, vmode, n64_480i, mode_valid}, 32'd0);
   endtask

   // n lines of (hsync low, hsync high) sync words, then a falling-nVSYNC word.
   task automatic field(input int n, input logic ev, input logic e4, input logic em, input string tag);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 7'b000_1100);
         step(1'b0, 7'b000_1111);
      end
      step(1'b0, 7'b000_0100);
      check({tag, "_vmode"}, {31'd0, vmode}, {31'd0, ev});
      check({tag, "_480i"}, {31'd0, n64_480i}, {31'd0, e4});
      check({tag, "_mvalid"}, {31'd0, mode_valid}, {31'd0, em});
   endtask

   initial begin
      vecs[0]  = '{1'b0, 7'h0F, 1'b0, 4'hF, {4'hF, 7'h00, 7'h00, 7'h00}};
      vecs[1]  = '{1'b1, 7'h12, 1'b0, 4'hF, {4'hF, 7'h00, 7'h00, 7'h00}};
      vecs[2]  = '{1'b1, 7'h34, 1'b0, 4'hF, {4'hF, 7'h00, 7'h00, 7'h00}};
      vecs[3]  = '{1'b1, 7'h56, 1'b1, 4'hF, {4'hF, 7'h12, 7'h34, 7'h56}};
      vecs[4]  = '{1'b1, 7'h11, 1'b0, 4'hF, {4'hF, 7'h12, 7'h34, 7'h56}};
      vecs[5]  = '{1'b0, 7'h7A, 1'b0, 4'hA, {4'hF, 7'h12, 7'h34, 7'h56}};
      vecs[6]  = '{1'b1, 7'h7F, 1'b0, 4'hA, {4'hF, 7'h12, 7'h34, 7'h56}};
      vecs[7]  = '{1'b0, 7'h05, 1'b0, 4'h5, {4'hF, 7'h12, 7'h34, 7'h56}};
      vecs[8]  = '{1'b1, 7'h01, 1'b0, 4'h5, {4'hF, 7'h12, 7'h34, 7'h56}};
      vecs[9]  = '{1'b1, 7'h02, 1'b0, 4'h5, {4'hF, 7'h12, 7'h34, 7'h56}};
      vecs[10] = '{1'b1, 7'h03, 1'b1, 4'h5, {4'h5, 7'h01, 7'h02, 7'h03}};
      vecs[11] = '{1'b0, 7'h0C, 1'b0, 4'hC, {4'h5, 7'h01, 7'h02, 7'h03}};
      vecs[12] = '{1'b1, 7'h7F, 1'b0, 4'hC, {4'h5, 7'h01, 7'h02, 7'h03}};
      vecs[13] = '{1'b1, 7'h00, 1'b0, 4'hC, {4'h5, 7'h01, 7'h02, 7'h03}};
      vecs[14] = '{1'b1, 7'h2A, 1'b1, 4'hC, {4'hC, 7'h7F, 7'h00, 7'h2A}};
      vecs[15] = '{1'b1, 7'h33, 1'b0, 4'hC, {4'hC, 7'h7F, 7'h00, 7'h2A}};
      vecs[16] = '{1'b0, 7'h03, 1'b0, 4'h3, {4'hC, 7'h7F, 7'h00, 7'h2A}};
      vecs[17] = '{1'b1, 7'h40, 1'b0, 4'h3, {4'hC, 7'h7F, 7'h00, 7'h2A}};
      vecs[18] = '{1'b1, 7'h41, 1'b0, 4'h3, {4'hC, 7'h7F, 7'h00, 7'h2A}};
      vecs[19] = '{1'b1, 7'h42, 1'b1, 4'h3, {4'h3, 7'h40, 7'h41, 7'h42}};

      nRST = 1'b0;
      step(1'b1, 7'h00);
      step(1'b1, 7'h00);
      check_reset_state("rst0");
      nRST = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].nd, vecs[i].d);
         check($sformatf("vec%0d_strb", i), {31'd0, pix_strb}, {31'd0, vecs[i].e_strb});
         check($sformatf("vec%0d_sync", i), {28'd0, Sync_o}, {28'd0, vecs[i].e_sync});
         check($sformatf("vec%0d_vdata", i), {7'd0, vdata_o}, {7'd0, vecs[i].e_vdata});
      end

      // Reset asserted mid-group (in GRN), then words without a fresh sync must not commit.
      step(1'b0, 7'h06);
      step(1'b1, 7'h21);
      nRST = 1'b0;
      step(1'b1, 7'h22);
      check_reset_state("rst_grn");
      nRST = 1'b1;
      step(1'b1, 7'h23);
      step(1'b1, 7'h24);
      step(1'b1, 7'h25);
      check("rst_nocommit_strb", {31'd0, pix_strb}, 32'd0);
      check("rst_nocommit_vdata", {7'd0, vdata_o}, {7'd0, 4'hF, 21'd0});
      step(1'b0, 7'h09);
      step(1'b1, 7'h31);
      step(1'b1, 7'h32);
      step(1'b1, 7'h33);
      check("post_rst_strb", {31'd0, pix_strb}, 32'd1);
      check("post_rst_vdata", {7'd0, vdata_o}, {7'd0, 4'h9, 7'h31, 7'h32, 7'h33});
      step(1'b1, 7'h00);
      check("post_rst_strb_low", {31'd0, pix_strb}, 32'd0);

      // Mode detection from a clean counter state.
      nRST = 1'b0;
      step(1'b1, 7'h00);
      nRST = 1'b1;
      check_reset_state("rst_mode");
      field(312, 1'b1, 1'b0, 1'b0, "pal_f1");
      field(313, 1'b1, 1'b1, 1'b1, "pal_f2");
      field(312, 1'b1, 1'b1, 1'b1, "pal_f3");
      field(313, 1'b1, 1'b1, 1'b1, "pal_f4");
      field(263, 1'b0, 1'b0, 1'b1, "ntsc_f1");
      field(263, 1'b0, 1'b0, 1'b1, "ntsc_f2");

      // Falling nVSYNC with rising nHSYNC: 287 must be judged, not 288.
      for (int i = 0; i < 287; i++) begin
         step(1'b0, 7'b000_1100);
         step(1'b0, 7'b000_1111);
      end
      step(1'b0, 7'b000_1101);
      step(1'b0, 7'b000_0111);
      check("combo_vmode", {31'd0, vmode}, 32'd0);
      check("combo_480i", {31'd0, n64_480i}, 32'd0);
      // A leftover count of 1 would make this 264 lines and flip 480i.
      field(263, 1'b0, 1'b0, 1'b1, "combo_next");

      // Saturation: 1030 lines reads as 1023.
      field(1030, 1'b1, 1'b0, 1'b1, "sat");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
